l2_pool_sched: RTL and testbench
================================

# l2_pool_sched

Sequences 2×2 max-pooling readout of the layer-2 pool line buffers (line0/line1, 12 columns each) once the row controller signals a completed line pair. Issues column reads to both lines, reduces each 2×2 window to one value, and delivers 6 pooled results per line pair over a valid/ready stream. Sits between the layer-2 row/line controller plus line buffers and the layer-3 input / result writer.

## Interface
- COLS, 12, columns per line; even, ≥2; outputs per pair = COLS/2
- DW, 8, pixel width, unsigned compare
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- ConvValid_i  in  1  layer enable; low = synchronous abort/clear
- PairReady_i  in  1  one-cycle pulse: line pair complete (row controller vbit)
- RsZero_i  in  1  qualifies PairReady_i: this pair is the frame's final, single-line (line0 only) row
- RdEn_o  out  1  line-buffer read strobe (both lines)
- RdAddr_o  out  4  column address, 0..COLS-1
- Line0Data_i  in  DW  line0 read data, valid 1 cycle after RdEn_o
- Line1Data_i  in  DW  line1 read data, valid 1 cycle after RdEn_o
- PoolData_o  out  DW  pooled result
- PoolValid_o  out  1  result valid
- PoolReady_i  in  1  downstream accept
- RowIdx_o  out  4  output row index of current pair
- Busy_o  out  1  FSM not in IDLE
- FrameDone_o  out  1  one-cycle pulse at frame end
- Overrun_o  out  1  sticky: pair arrived while busy

## Operation
- FSM states: IDLE, RD_EVEN, RD_ODD, CMP, HOLD. Column-pair counter k (0..COLS/2-1), row counter RowIdx.
- IDLE: on ConvValid_i & PairReady_i → RD_EVEN, k=0; latch RsZero_i as LastPair.
- RD_EVEN: RdEn_o=1, RdAddr_o=2k → RD_ODD.
- RD_ODD: RdEn_o=1, RdAddr_o=2k+1; capture Acc = max(L0,L1) of even column → CMP.
- CMP: PoolData_o reg ← max(Acc, L0, L1) of odd column; PoolValid_o=1 → HOLD.
- HOLD: hold PoolData_o/PoolValid_o stable until PoolValid_o & PoolReady_i. On handshake: if k<COLS/2-1 → RD_EVEN, k+1 (same edge); else → IDLE, RowIdx+1, and if LastPair: FrameDone_o pulse, RowIdx ← 0.
- LastPair pooling: line1 data ignored (treated as 0); see Configuration.
- Overrun: PairReady_i while state≠IDLE sets Overrun_o; pulse dropped, current pair continues unaffected.
- PairReady_i while ConvValid_i low: ignored.
- ConvValid_i low (any state): next edge → IDLE, k=0, RowIdx=0, PoolValid_o=0, Overrun_o=0, no FrameDone_o.
- RowIdx wraps only via LastPair completion; no saturation logic beyond 4 bits.

## Timing
- Reset: all outputs 0 (RdAddr_o=0, PoolData_o=0, RowIdx_o=0, FSM IDLE).
- RdEn_o/RdAddr_o registered-free: decoded from state/k, same cycle as state.
- PairReady_i at edge t → first RdEn_o in cycle t+1; first PoolValid_o at t+4.
- Minimum 4 cycles per output with PoolReady_i=1 held: full pair = 24 cycles from PairReady_i to last handshake.
- PoolReady_i asserted before PoolValid_o has no effect; handshake only in HOLD.
- Busy_o=1 from the cycle after PairReady_i until return to IDLE; FrameDone_o concurrent with IDLE re-entry cycle.
- Simultaneous final handshake and new PairReady_i: counts as overrun (state≠IDLE at that edge).

## Configuration
- POOL_ODD_ROW_EN defined: LastPair pair pooled 1×2 from line0 only (6 outputs, max of two line0 columns); FrameDone_o after its 6th handshake; 13 output rows for a 25-row frame.
- Undefined: LastPair pair performs no reads and no outputs; FSM stays IDLE, FrameDone_o pulses the cycle after PairReady_i, RowIdx ← 0; 12 output rows per frame.

## Test plan
- Reset then ConvValid_i=1, line0=0..11, line1=20..31, one PairReady_i, PoolReady_i=1 → outputs 21,23,25,27,29,31 at 4-cycle spacing; RowIdx_o 0→1; Busy_o low after 24 cycles.
- Same data, PoolReady_i low 5 cycles on 3rd output → PoolData_o=25 held stable, RdEn_o=0 during stall, sequence completes unchanged.
- PairReady_i re-pulsed 10 cycles after first → Overrun_o=1 sticky, outputs of first pair intact, no second pair processed.
- 12 normal pairs then PairReady_i+RsZero_i, line0=5,9,… → with POOL_ODD_ROW_EN: 6 outputs = 9,… and FrameDone_o after 6th; without: no outputs, FrameDone_o next cycle; RowIdx_o=0 after.
- ConvValid_i dropped in HOLD mid-pair → next cycle PoolValid_o=0, Busy_o=0, RowIdx_o=0, Overrun_o=0; fresh pair restarts at column 0.
- rstn asserted mid-RD_ODD → all outputs 0 immediately (asynchronously); no FrameDone_o.

Source files
------------

// File: rtl/l2_pool_sched.sv
// l2_pool_sched: 2x2 max-pooling readout sequencer for the layer-2 pool line buffers.
// Reads line0/line1 column pairs, reduces each 2x2 window to its maximum and streams
// COLS/2 results per line pair over a valid/ready handshake.
// Optional feature macro: POOL_ODD_ROW_EN (pool the frame's final single-line row 1x2
// from line0 only); when undefined that row produces no reads and no outputs.
module l2_pool_sched #(
    parameter int COLS = 12,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ConvValid_i,
    input  logic          PairReady_i,
    input  logic          RsZero_i,
    output logic          RdEn_o,
    output logic [3:0]    RdAddr_o,
    input  logic [DW-1:0] Line0Data_i,
    input  logic [DW-1:0] Line1Data_i,
    output logic [DW-1:0] PoolData_o,
    output logic          PoolValid_o,
    input  logic          PoolReady_i,
    output logic [3:0]    RowIdx_o,
    output logic          Busy_o,
    output logic          FrameDone_o,
    output logic          Overrun_o
);

    localparam int NPOOL = COLS / 2;
    localparam int KW    = (NPOOL > 1) ? $clog2(NPOOL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NPOOL - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_EVEN = 3'd1,
        RD_ODD  = 3'd2,
        CMP     = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t        state_r;
    logic [KW-1:0] kCnt_r;
    logic [3:0]    rowIdx_r;
    logic          lastPair_r;
    logic [DW-1:0] acc_r;
    logic [DW-1:0] poolData_r;
    logic          poolValid_r;
    logic          frameDone_r;
    logic          overrun_r;

    logic          rdEn_s;
    logic [3:0]    rdAddr_s;
    logic [DW-1:0] line1Eff_s;
    logic [DW-1:0] colMax_s;

    // Unsigned maximum of two pixels.
    function automatic logic [DW-1:0] maxOf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Read strobe and column address decoded straight from state and column-pair counter.
    always_comb begin
        rdEn_s   = 1'b0;
        rdAddr_s = 4'd0;
        case (state_r)
            RD_EVEN: begin
                rdEn_s   = 1'b1;
                rdAddr_s = 4'({kCnt_r, 1'b0});
            end
            RD_ODD: begin
                rdEn_s   = 1'b1;
                rdAddr_s = 4'({kCnt_r, 1'b1});
            end
            default: begin
                rdEn_s   = 1'b0;
                rdAddr_s = 4'd0;
            end
        endcase
    end

    // Column maximum of the returning read data; the single-line final row has no line1.
    always_comb begin
        line1Eff_s = Line1Data_i;
        if (lastPair_r) begin
            line1Eff_s = {DW{1'b0}};
        end else begin
            line1Eff_s = Line1Data_i;
        end
        colMax_s = maxOf(Line0Data_i, line1Eff_s);
    end

    // Pooling FSM with counters, result register and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            kCnt_r      <= '0;
            rowIdx_r    <= 4'd0;
            lastPair_r  <= 1'b0;
            acc_r       <= '0;
            poolData_r  <= '0;
            poolValid_r <= 1'b0;
            frameDone_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (!ConvValid_i) begin
            // Layer disabled: abandon any pair in flight and clear row/status state.
            state_r     <= IDLE;
            kCnt_r      <= '0;
            rowIdx_r    <= 4'd0;
            lastPair_r  <= 1'b0;
            poolValid_r <= 1'b0;
            frameDone_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frameDone_r <= 1'b0;
            // A pair arriving while a pair is in flight is dropped but remembered.
            if (PairReady_i && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (PairReady_i) begin
                        kCnt_r <= '0;
`ifdef POOL_ODD_ROW_EN
                        lastPair_r <= RsZero_i;
                        state_r    <= RD_EVEN;
`else
                        lastPair_r <= 1'b0;
                        if (RsZero_i) begin
                            // Final single-line row is skipped: just close the frame.
                            frameDone_r <= 1'b1;
                            rowIdx_r    <= 4'd0;
                            state_r     <= IDLE;
                        end else begin
                            state_r <= RD_EVEN;
                        end
`endif
                    end
                end
                RD_EVEN: begin
                    state_r <= RD_ODD;
                end
                RD_ODD: begin
                    acc_r   <= colMax_s;
                    state_r <= CMP;
                end
                CMP: begin
                    poolData_r  <= maxOf(acc_r, colMax_s);
                    poolValid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (PoolReady_i) begin
                        poolValid_r <= 1'b0;
                        if (kCnt_r != K_LAST) begin
                            kCnt_r  <= kCnt_r + KW'(1);
                            state_r <= RD_EVEN;
                        end else begin
                            kCnt_r     <= '0;
                            lastPair_r <= 1'b0;
                            state_r    <= IDLE;
                            if (lastPair_r) begin
                                frameDone_r <= 1'b1;
                                rowIdx_r    <= 4'd0;
                            end else begin
                                rowIdx_r <= rowIdx_r + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    kCnt_r      <= '0;
                    poolValid_r <= 1'b0;
                end
            endcase
        end
    end

    assign RdEn_o      = rdEn_s;
    assign RdAddr_o    = rdAddr_s;
    assign PoolData_o  = poolData_r;
    assign PoolValid_o = poolValid_r;
    assign RowIdx_o    = rowIdx_r;
    assign Busy_o      = (state_r != IDLE);
    assign FrameDone_o = frameDone_r;
    assign Overrun_o   = overrun_r;

endmodule

// File: tb/tb_l2_pool_sched.sv
// Self-checking bench for l2_pool_sched: line-buffer model, result scoreboard and
// one task per scenario. Expectations follow the POOL_ODD_ROW_EN setting of the build.
module tb_l2_pool_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ConvValid_i;
    logic       PairReady_i;
    logic       RsZero_i;
    logic       RdEn_o;
    logic [3:0] RdAddr_o;
    logic [7:0] Line0Data_i;
    logic [7:0] Line1Data_i;
    logic [7:0] PoolData_o;
    logic       PoolValid_o;
    logic       PoolReady_i;
    logic [3:0] RowIdx_o;
    logic       Busy_o;
    logic       FrameDone_o;
    logic       Overrun_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] line0Mem [12];
    logic [7:0] line1Mem [12];
    logic [7:0] expQ [$];
    logic [7:0] monExp;

    l2_pool_sched #(.COLS(12), .DW(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ConvValid_i (ConvValid_i),
        .PairReady_i (PairReady_i),
        .RsZero_i    (RsZero_i),
        .RdEn_o      (RdEn_o),
        .RdAddr_o    (RdAddr_o),
        .Line0Data_i (Line0Data_i),
        .Line1Data_i (Line1Data_i),
        .PoolData_o  (PoolData_o),
        .PoolValid_o (PoolValid_o),
        .PoolReady_i (PoolReady_i),
        .RowIdx_o    (RowIdx_o),
        .Busy_o      (Busy_o),
        .FrameDone_o (FrameDone_o),
        .Overrun_o   (Overrun_o)
    );

    always #5 clk = ~clk;

    // Line-buffer model: read data returns one cycle after the strobe.
    always @(posedge clk) begin
        if (RdEn_o) begin
            Line0Data_i <= line0Mem[RdAddr_o];
            Line1Data_i <= line1Mem[RdAddr_o];
        end
    end

    // Scoreboard: every handshake pops and compares the next expected result.
    always @(negedge clk) begin
        if (rstn && PoolValid_o && PoolReady_i) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL pool_data unexpected output got %0d want none", PoolData_o);
            end else begin
                monExp = expQ.pop_front();
                if (PoolData_o !== monExp) begin
                    miscompares++;
                    $display("FAIL pool_data got %0d want %0d", PoolData_o, monExp);
                end
            end
        end
    end

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse PairReady_i for one edge; optionally queue the results the pair should yield.
    task automatic pulsePair(input logic rs, input logic push);
        if (push) begin
            for (int k = 0; k < 6; k++) begin
                if (rs)
                    expQ.push_back(mx(line0Mem[2*k], line0Mem[2*k+1]));
                else
                    expQ.push_back(mx(mx(line0Mem[2*k], line0Mem[2*k+1]),
                                      mx(line1Mem[2*k], line1Mem[2*k+1])));
            end
        end
        PairReady_i = 1'b1;
        RsZero_i    = rs;
        tick();
        PairReady_i = 1'b0;
        RsZero_i    = 1'b0;
    endtask

    task automatic waitIdle(input int budget, output int n);
        n = 0;
        while (Busy_o && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic loadRamp();
        for (int i = 0; i < 12; i++) begin
            line0Mem[i] = 8'(i);
            line1Mem[i] = 8'(20 + i);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({RdEn_o, RdAddr_o, PoolData_o, PoolValid_o, RowIdx_o, Busy_o, FrameDone_o, Overrun_o} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0",
                     {RdEn_o, RdAddr_o, PoolData_o, PoolValid_o, RowIdx_o, Busy_o, FrameDone_o, Overrun_o});
        end
        tick();
        rstn = 1'b1;
        ConvValid_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        int firstValid;
        int nValid;
        loadRamp();
        PoolReady_i = 1'b1;
        pulsePair(1'b0, 1'b1);
        vectors++;
        if (RdEn_o !== 1'b1 || RdAddr_o !== 4'd0 || Busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first_read got en=%0d addr=%0d busy=%0d want 1 0 1", RdEn_o, RdAddr_o, Busy_o);
        end
        n = 0; firstValid = -1; nValid = 0;
        while (Busy_o && n < 60) begin
            if (PoolValid_o) begin
                nValid++;
                if (firstValid < 0) firstValid = n;
            end
            tick();
            n++;
        end
        vectors++;
        if (n !== 24) begin
            miscompares++;
            $display("FAIL basic_pair_cycles got %0d want 24", n);
        end
        vectors++;
        if (firstValid !== 3 || nValid !== 6) begin
            miscompares++;
            $display("FAIL basic_valid_timing got first=%0d count=%0d want 3 6", firstValid, nValid);
        end
        vectors++;
        if (RowIdx_o !== 4'd1 || expQ.size() !== 0) begin
            miscompares++;
            $display("FAIL basic_rowidx got row=%0d pending=%0d want 1 0", RowIdx_o, expQ.size());
        end
    endtask

    task automatic test_stall();
        int n;
        int nv;
        int m;
        loadRamp();
        PoolReady_i = 1'b1;
        pulsePair(1'b0, 1'b1);
        n = 0; nv = 0;
        while (n < 40) begin
            if (PoolValid_o) begin
                nv++;
                if (nv == 3) break;
            end
            tick();
            n++;
        end
        PoolReady_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            vectors++;
            if (PoolData_o !== 8'd25 || PoolValid_o !== 1'b1 || RdEn_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got data=%0d valid=%0d rden=%0d want 25 1 0",
                         s, PoolData_o, PoolValid_o, RdEn_o);
            end
            tick();
        end
        PoolReady_i = 1'b1;
        waitIdle(60, m);
        vectors++;
        if (n + 5 + m !== 29) begin
            miscompares++;
            $display("FAIL stall_pair_cycles got %0d want 29", n + 5 + m);
        end
        vectors++;
        if (RowIdx_o !== 4'd2 || expQ.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_rowidx got row=%0d pending=%0d want 2 0", RowIdx_o, expQ.size());
        end
    endtask

    task automatic test_overrun();
        int n;
        loadRamp();
        PoolReady_i = 1'b1;
        pulsePair(1'b0, 1'b1);
        repeat (9) tick();
        pulsePair(1'b0, 1'b0);
        vectors++;
        if (Overrun_o !== 1'b1 || Busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set got ovr=%0d busy=%0d want 1 1", Overrun_o, Busy_o);
        end
        waitIdle(60, n);
        repeat (6) tick();
        vectors++;
        if (Busy_o !== 1'b0 || Overrun_o !== 1'b1 || RowIdx_o !== 4'd3 || expQ.size() !== 0) begin
            miscompares++;
            $display("FAIL overrun_after got busy=%0d ovr=%0d row=%0d pending=%0d want 0 1 3 0",
                     Busy_o, Overrun_o, RowIdx_o, expQ.size());
        end
    endtask

    task automatic test_abort();
        int n;
        loadRamp();
        PoolReady_i = 1'b0;
        pulsePair(1'b0, 1'b1);
        n = 0;
        while (!PoolValid_o && n < 20) begin
            tick();
            n++;
        end
        pulsePair(1'b0, 1'b0);
        vectors++;
        if (PoolValid_o !== 1'b1 || PoolData_o !== 8'd21 || Overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_in_hold got valid=%0d data=%0d ovr=%0d want 1 21 1",
                     PoolValid_o, PoolData_o, Overrun_o);
        end
        ConvValid_i = 1'b0;
        tick();
        vectors++;
        if (PoolValid_o !== 1'b0 || Busy_o !== 1'b0 || RowIdx_o !== 4'd0 ||
            Overrun_o !== 1'b0 || FrameDone_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear got valid=%0d busy=%0d row=%0d ovr=%0d fd=%0d want 0 0 0 0 0",
                     PoolValid_o, Busy_o, RowIdx_o, Overrun_o, FrameDone_o);
        end
        expQ.delete();
        ConvValid_i = 1'b1;
        PoolReady_i = 1'b1;
        pulsePair(1'b0, 1'b1);
        vectors++;
        if (RdEn_o !== 1'b1 || RdAddr_o !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_restart got en=%0d addr=%0d want 1 0", RdEn_o, RdAddr_o);
        end
        waitIdle(60, n);
        vectors++;
        if (n !== 24 || RowIdx_o !== 4'd1 || expQ.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_fresh_pair got cycles=%0d row=%0d pending=%0d want 24 1 0",
                     n, RowIdx_o, expQ.size());
        end
    endtask

    task automatic test_async_reset();
        loadRamp();
        PoolReady_i = 1'b1;
        pulsePair(1'b0, 1'b1);
        tick();
        vectors++;
        if (RdEn_o !== 1'b1 || RdAddr_o !== 4'd1) begin
            miscompares++;
            $display("FAIL areset_pre got en=%0d addr=%0d want 1 1", RdEn_o, RdAddr_o);
        end
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if ({RdEn_o, RdAddr_o, PoolData_o, PoolValid_o, RowIdx_o, Busy_o, FrameDone_o, Overrun_o} !== 21'd0) begin
            miscompares++;
            $display("FAIL areset_outputs got %h want 0",
                     {RdEn_o, RdAddr_o, PoolData_o, PoolValid_o, RowIdx_o, Busy_o, FrameDone_o, Overrun_o});
        end
        expQ.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        vectors++;
        if (FrameDone_o !== 1'b0 || Busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_after got fd=%0d busy=%0d want 0 0", FrameDone_o, Busy_o);
        end
    endtask

    task automatic test_frame();
        int n;
        int bad;
        logic [7:0] lastRow [12];
        lastRow = '{8'd5, 8'd9, 8'd30, 8'd12, 8'd7, 8'd40, 8'd50, 8'd3, 8'd11, 8'd11, 8'd0, 8'd255};
        ConvValid_i = 1'b0;
        tick();
        ConvValid_i = 1'b1;
        PoolReady_i = 1'b1;
        bad = 0;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 12; i++) begin
                line0Mem[i] = 8'($urandom_range(0, 255));
                line1Mem[i] = 8'($urandom_range(0, 255));
            end
            pulsePair(1'b0, 1'b1);
            waitIdle(60, n);
            if (n != 24) bad++;
        end
        vectors++;
        if (bad !== 0 || RowIdx_o !== 4'd12) begin
            miscompares++;
            $display("FAIL frame_12_pairs got bad=%0d row=%0d want 0 12", bad, RowIdx_o);
        end
        for (int i = 0; i < 12; i++) begin
            line0Mem[i] = lastRow[i];
            line1Mem[i] = 8'd250;
        end
`ifdef POOL_ODD_ROW_EN
        pulsePair(1'b1, 1'b1);
        n = 0;
        while (!FrameDone_o && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (FrameDone_o !== 1'b1 || Busy_o !== 1'b0 || RowIdx_o !== 4'd0 || expQ.size() !== 0 || n !== 24) begin
            miscompares++;
            $display("FAIL frame_last_pooled got fd=%0d busy=%0d row=%0d pending=%0d cyc=%0d want 1 0 0 0 24",
                     FrameDone_o, Busy_o, RowIdx_o, expQ.size(), n);
        end
`else
        pulsePair(1'b1, 1'b0);
        vectors++;
        if (FrameDone_o !== 1'b1 || Busy_o !== 1'b0 || RowIdx_o !== 4'd0 || RdEn_o !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_last_skipped got fd=%0d busy=%0d row=%0d rden=%0d want 1 0 0 0",
                     FrameDone_o, Busy_o, RowIdx_o, RdEn_o);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (Busy_o || RdEn_o || PoolValid_o) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL frame_no_activity got %0d active cycles want 0", bad);
        end
`endif
        tick();
        vectors++;
        if (FrameDone_o !== 1'b0 || RowIdx_o !== 4'd0) begin
            miscompares++;
            $display("FAIL frame_done_pulse got fd=%0d row=%0d want 0 0", FrameDone_o, RowIdx_o);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        ConvValid_i = 1'b0;
        PairReady_i = 1'b0;
        RsZero_i    = 1'b0;
        PoolReady_i = 1'b0;
        Line0Data_i = 8'd0;
        Line1Data_i = 8'd0;
        for (int i = 0; i < 12; i++) begin
            line0Mem[i] = 8'd0;
            line1Mem[i] = 8'd0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_abort();
        test_async_reset();
        test_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
